// File: rtl/eth_mii_pkg.sv
// Shared definitions for the MII receive frame checker.
// Holds the receive FSM state encoding, the frame classification
// encoding, the Ethernet CRC-32 constants, the preamble/SFD nibble
// values and small helper functions used by the checker and its
// CRC sub-module.
package eth_mii_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  // Outcome of a completed frame; selects which statistics counter moves.
  typedef enum logic [1:0] {
    FC_GOOD = 2'd0,
    FC_CRC  = 2'd1,
    FC_LEN  = 2'd2,
    FC_SYM  = 2'd3
  } frame_class_e;

  // IEEE 802.3 CRC-32, normal (MSB-first) polynomial form.
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left behind after running a correct FCS through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [3:0]  NIB_PREAMBLE = 4'h5;
  localparam logic [3:0]  NIB_SFD      = 4'hD;

  localparam logic [10:0] BYTE_CNT_MAX = 11'd2047;
  localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

  // Bit-reverse a 32-bit word (turns the normal polynomial into LSB-first form).
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Saturating increment for the 16-bit frame statistics.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == STAT_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mii_crc32_nib.sv
// Combinational one-nibble step of the reflected Ethernet CRC-32.
// Ports:
//   data    - 4-bit MII nibble, bit 0 is the first bit on the wire
//   crc_in  - current CRC register
//   crc_out - CRC register after absorbing the nibble
module mii_crc32_nib
  import eth_mii_pkg::*;
(
  input  logic [3:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  logic [31:0] poly_refl_s;
  logic [31:0] crc_s;

  // Shift the four data bits through the LSB-first LFSR.
  always_comb begin
    poly_refl_s = reflect32(CRC_POLY);
    crc_s       = crc_in;
    for (int i = 0; i < 4; i++) begin
      if ((crc_s[0] ^ data[i]) == 1'b1) begin
        crc_s = (crc_s >> 1) ^ poly_refl_s;
      end else begin
        crc_s = crc_s >> 1;
      end
    end
    crc_out = crc_s;
  end

endmodule

// File: rtl/mii_rx_frame_checker.sv
// MII receive frame checker.
// Locks onto preamble + SFD, assembles nibble pairs into bytes, checks
// the CRC-32 and frame length, strips the 4-byte FCS and streams the
// payload out as single-cycle beats (no backpressure). Every frame that
// reaches the data phase is classified once into good / crc / len / sym.
// Ports:
//   clk, rst_n           - MII nibble clock, async active-low reset
//   mii_d, mii_en, mii_er - MII nibble, enable (rx_dv) and error (rx_er)
//   m_tdata/m_tvalid     - payload byte stream, FCS removed
//   m_tlast/m_tuser      - last payload byte / frame bad (valid with m_tlast)
//   cnt_good/crc/len/sym - saturating per-outcome frame counters
module mii_rx_frame_checker
  import eth_mii_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 32'd2,
  parameter int unsigned MIN_FRAME    = 32'd64,
  parameter int unsigned MAX_FRAME    = 32'd1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mii_d,
  input  logic        mii_en,
  input  logic        mii_er,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_crc,
  output logic [15:0] cnt_len,
  output logic [15:0] cnt_sym
);

  rx_state_e    state_r;
  rx_state_e    state_s;

  logic [7:0]   pre_cnt_r;
  logic [3:0]   nib_lo_r;
  logic         nib_phase_r;   // 1 while holding the low nibble of a byte
  logic [10:0]  byte_cnt_r;
  logic [31:0]  crc_r;
  logic [31:0]  crc_nxt_s;
  logic         sym_err_r;
  logic [7:0]   dly_r [4];     // dly_r[0] newest, dly_r[3] oldest
  logic [7:0]   hold_r;

  logic         pre_start_s;
  logic         pre_inc_s;
  logic         pre_ok_s;
  logic         sfd_ok_s;
  logic         nib_s;
  logic         byte_done_s;
  logic         frame_end_s;
  logic         overflow_s;
  logic         hold_vld_s;
  logic [10:0]  byte_cnt_inc_s;
  frame_class_e cls_s;
  frame_class_e stat_cls_s;
  logic         stat_inc_s;

  logic         out_vld_s;
  logic         out_last_s;
  logic         out_user_s;
  logic [7:0]   out_data_s;

  logic [7:0]   m_tdata_r;
  logic         m_tvalid_r;
  logic         m_tlast_r;
  logic         m_tuser_r;
  logic [15:0]  cnt_good_r;
  logic [15:0]  cnt_crc_r;
  logic [15:0]  cnt_len_r;
  logic [15:0]  cnt_sym_r;

  mii_crc32_nib u_crc (
    .data    (mii_d),
    .crc_in  (crc_r),
    .crc_out (crc_nxt_s)
  );

  assign pre_ok_s       = (32'(pre_cnt_r) >= MIN_PREAMBLE);
  assign byte_done_s    = (state_r == DATA) && mii_en && nib_phase_r;
  assign byte_cnt_inc_s = (byte_cnt_r == BYTE_CNT_MAX) ? byte_cnt_r : (byte_cnt_r + 11'd1);
  assign overflow_s     = byte_done_s && (32'(byte_cnt_inc_s) > MAX_FRAME);
  // Five completed bytes means four sit in the FCS delay line and one in hold.
  assign hold_vld_s     = (byte_cnt_r >= 11'd5);
  assign stat_inc_s     = frame_end_s || overflow_s;
  assign stat_cls_s     = overflow_s ? FC_LEN : cls_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and datapath strobes; mii_en low always wins.
  always_comb begin
    state_s     = state_r;
    pre_start_s = 1'b0;
    pre_inc_s   = 1'b0;
    sfd_ok_s    = 1'b0;
    nib_s       = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!mii_en) begin
          state_s = IDLE;
        end else if (mii_d == NIB_PREAMBLE) begin
          state_s     = PRE;
          pre_start_s = 1'b1;
        end else begin
          state_s = DROP;
        end
      end
      PRE: begin
        if (!mii_en) begin
          state_s = IDLE;
        end else if (mii_er) begin
          state_s = DROP;
        end else if (mii_d == NIB_PREAMBLE) begin
          pre_inc_s = 1'b1;
        end else if ((mii_d == NIB_SFD) && pre_ok_s) begin
          state_s  = DATA;
          sfd_ok_s = 1'b1;
        end else begin
          state_s = DROP;
        end
      end
      DATA: begin
        if (!mii_en) begin
          state_s     = IDLE;
          frame_end_s = 1'b1;
        end else begin
          nib_s = 1'b1;
          if (overflow_s) begin
            state_s = DROP;
          end else begin
            state_s = DATA;
          end
        end
      end
      DROP: begin
        if (!mii_en) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Frame classification as seen at the end of the data phase.
  always_comb begin
    if (sym_err_r || nib_phase_r) begin
      cls_s = FC_SYM;
    end else if ((32'(byte_cnt_r) < MIN_FRAME) || (32'(byte_cnt_r) > MAX_FRAME)) begin
      cls_s = FC_LEN;
    end else if (crc_r != CRC_RESIDUE) begin
      cls_s = FC_CRC;
    end else begin
      cls_s = FC_GOOD;
    end
  end

  // Preamble counting, byte assembly, CRC and FCS delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_r   <= 8'd0;
      nib_lo_r    <= 4'd0;
      nib_phase_r <= 1'b0;
      byte_cnt_r  <= 11'd0;
      crc_r       <= 32'd0;
      sym_err_r   <= 1'b0;
      hold_r      <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        dly_r[i] <= 8'd0;
      end
    end else begin
      if (pre_start_s) begin
        pre_cnt_r <= 8'd1;
      end else if (pre_inc_s && (pre_cnt_r != 8'hFF)) begin
        pre_cnt_r <= pre_cnt_r + 8'd1;
      end

      if (sfd_ok_s) begin
        crc_r       <= CRC_INIT;
        byte_cnt_r  <= 11'd0;
        nib_phase_r <= 1'b0;
        sym_err_r   <= 1'b0;
      end else if (nib_s) begin
        crc_r       <= crc_nxt_s;
        nib_phase_r <= ~nib_phase_r;
        if (mii_er) begin
          sym_err_r <= 1'b1;
        end
        if (!nib_phase_r) begin
          nib_lo_r <= mii_d;
        end else begin
          // Oldest delay-line byte becomes the next byte to emit.
          hold_r <= dly_r[3];
          for (int i = 3; i > 0; i--) begin
            dly_r[i] <= dly_r[i-1];
          end
          dly_r[0]   <= {mii_d, nib_lo_r};
          byte_cnt_r <= byte_cnt_inc_s;
        end
      end
    end
  end

  // Output beat selection: end of frame, oversize cut-off, or a normal byte.
  always_comb begin
    out_vld_s  = 1'b0;
    out_last_s = 1'b0;
    out_user_s = 1'b0;
    out_data_s = m_tdata_r;
    if (frame_end_s) begin
      if (hold_vld_s) begin
        out_vld_s  = 1'b1;
        out_last_s = 1'b1;
        out_user_s = (cls_s != FC_GOOD);
        out_data_s = hold_r;
      end else begin
        out_vld_s = 1'b0;
      end
    end else if (overflow_s) begin
      // Close the stream even if nothing has been emitted yet.
      out_vld_s  = 1'b1;
      out_last_s = 1'b1;
      out_user_s = 1'b1;
      out_data_s = hold_vld_s ? hold_r : 8'h00;
    end else if (byte_done_s && hold_vld_s) begin
      out_vld_s  = 1'b1;
      out_data_s = hold_r;
    end else begin
      out_vld_s = 1'b0;
    end
  end

  // Registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata_r  <= 8'h00;
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
      m_tuser_r  <= 1'b0;
    end else begin
      m_tdata_r  <= out_data_s;
      m_tvalid_r <= out_vld_s;
      m_tlast_r  <= out_last_s;
      m_tuser_r  <= out_user_s;
    end
  end

  // Per-outcome frame statistics; exactly one moves per finished frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good_r <= 16'd0;
      cnt_crc_r  <= 16'd0;
      cnt_len_r  <= 16'd0;
      cnt_sym_r  <= 16'd0;
    end else if (stat_inc_s) begin
      case (stat_cls_s)
        FC_GOOD: cnt_good_r <= sat_inc16(cnt_good_r);
        FC_CRC:  cnt_crc_r  <= sat_inc16(cnt_crc_r);
        FC_LEN:  cnt_len_r  <= sat_inc16(cnt_len_r);
        FC_SYM:  cnt_sym_r  <= sat_inc16(cnt_sym_r);
        default: cnt_good_r <= cnt_good_r;
      endcase
    end
  end

  assign m_tdata  = m_tdata_r;
  assign m_tvalid = m_tvalid_r;
  assign m_tlast  = m_tlast_r;
  assign m_tuser  = m_tuser_r;
  assign cnt_good = cnt_good_r;
  assign cnt_crc  = cnt_crc_r;
  assign cnt_len  = cnt_len_r;
  assign cnt_sym  = cnt_sym_r;

endmodule

// File: doc/mii_rx_frame_checker.md
MII_RX_FRAME_CHECKER -- requirements
Module: mii_rx_frame_checker

Interface
REQ-001 SHALL have parameter MIN_PREAMBLE, default 2, meaning the minimum number of 0x5 nibbles accepted before the SFD nibble 0xD.
REQ-002 SHALL have parameter MIN_FRAME, default 64, meaning the minimum byte count after SFD (FCS included).
REQ-003 SHALL have parameter MAX_FRAME, default 1518, meaning the maximum byte count after SFD (FCS included).
REQ-004 clk  in  1  MII nibble clock (phy_tx_clk/phy_rx_clk domain, 25 MHz); sole clock.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 mii_d  in  4  MII data nibble, low nibble of each byte first.
REQ-007 mii_en  in  1  MII enable (tx_en / rx_dv).
REQ-008 mii_er  in  1  MII error (tx_er / rx_er).
REQ-009 m_tdata  out  8  payload byte, FCS stripped.
REQ-010 m_tvalid  out  1  byte valid; single-cycle per byte; no backpressure.
REQ-011 m_tlast  out  1  last payload byte of frame.
REQ-012 m_tuser  out  1  frame bad; meaningful only with m_tlast.
REQ-013 cnt_good, cnt_crc, cnt_len, cnt_sym  out  16 each  saturating frame counters.

Function
REQ-014 FSM states SHALL be IDLE, PRE, DATA, DROP.
REQ-015 IDLE->PRE when mii_en=1 and mii_d=0x5; mii_en=1 with any other nibble -> DROP.
REQ-016 PRE: 0x5 increments preamble count; 0xD with count>=MIN_PREAMBLE -> DATA; 0xD with count<MIN_PREAMBLE, any other nibble, or mii_er=1 -> DROP; mii_en=0 -> IDLE; no counter changes for any PRE/IDLE exit.
REQ-017 DROP SHALL remain until mii_en=0, then IDLE; no output, no counter change.
REQ-018 DATA: nibble pairs SHALL form bytes {second,first}; byte count is 11 bits, saturating at 2047.
REQ-019 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) SHALL be updated per nibble over all DATA nibbles including FCS; frame passes when register equals residue 0xDEBB20E3 at frame end.
REQ-020 Completed bytes SHALL pass a 4-byte delay line plus one hold register; byte N SHALL appear on m_tdata with m_tvalid=1 the cycle after byte N+5 completes.
REQ-021 Frame end (mii_en sampled 0 in DATA): held byte SHALL be emitted next cycle with m_tlast=1; remaining 4 delay-line bytes (FCS) discarded; FSM -> IDLE.
REQ-022 Frames with <5 bytes SHALL emit no output bytes but SHALL still be classified and counted.
REQ-023 Classification priority: sym (mii_er seen in DATA, or odd nibble count) > len (bytes<MIN_FRAME or >MAX_FRAME) > crc (residue mismatch) > good; exactly one counter increments, one cycle after frame end.
REQ-024 m_tuser SHALL be 1 on m_tlast unless the frame is good.
REQ-025 Byte count exceeding MAX_FRAME SHALL immediately emit the held byte with m_tlast=1, m_tuser=1 (or a 0x00 byte if hold empty), increment cnt_len, then -> DROP.
REQ-026 Counters SHALL saturate at 0xFFFF.
REQ-027 mii_en dropping in the same cycle as a preamble/SFD decision SHALL take the mii_en=0 path.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, clear delay line, hold, CRC, byte/preamble counts, all counters to 0, and m_tvalid=m_tlast=m_tuser=0, m_tdata=0x00.
REQ-029 Reset mid-frame SHALL discard the frame; after rst_n rises with mii_en still 1 and a non-0x5 nibble, FSM SHALL enter DROP.

Structure
REQ-030 FSM state enum, CRC polynomial, residue constant and SFD/preamble nibble constants SHALL reside in package eth_mii_pkg.
REQ-031 Per-nibble CRC update SHALL be sub-module mii_crc32_nib (4-bit data in, 32-bit state in/out, combinational), instantiated once.

Verification
REQ-032 15x0x5, 0xD, 60-byte payload 0x00..0x3B + correct FCS -> 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, cnt_good=1.
REQ-033 Same frame with one FCS bit flipped -> identical data, tuser=1, cnt_crc=1, cnt_good unchanged.
REQ-034 Valid 20-byte frame (runt) -> tlast tuser=1, cnt_len=1; 3-byte frame -> no beats, cnt_len=2.
REQ-035 mii_er=1 for one nibble mid-payload of valid 64-byte frame -> tuser=1, cnt_sym=1 (not cnt_crc).
REQ-036 Preamble 1x0x5 then 0xD (MIN_PREAMBLE=2) -> no output, no counter change; next valid frame -> cnt_good increments.
REQ-037 rst_n pulsed low at byte 30 of a frame -> outputs 0 immediately, counters 0, remainder dropped, next valid frame good.
